// File: rtl/brick_field_pkg.sv
// brick_field_pkg: shared timing constants, pixel type
// and brick indexing for the brick field renderer.
package brick_field_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef logic [2:0] rgb3_t;

  localparam logic [14:0] DEF_ROW_COLORS =
    15'b011_100_111_110_010;

  function automatic int brick_idx(
    input int row,
    input int col,
    input int cols
  );
    return row * cols + col;
  endfunction

endpackage

// File: rtl/brick_field_vga_if.sv
// brick_field_vga_if: erase request handshake between
// game logic (master) and the renderer (slave).
interface brick_field_vga_if #(
  parameter int IDXW = 5
);

  logic            erase_valid;
  logic [IDXW-1:0] erase_pos;
  logic            erase_ack;
  logic            erase_hit;

  modport master (
    output erase_valid, erase_pos,
    input  erase_ack, erase_hit
  );

  modport slave (
    input  erase_valid, erase_pos,
    output erase_ack, erase_hit
  );

endinterface

// File: rtl/brick_grid_locator.sv
// brick_grid_locator: tracks brick row/col for the current
// counters with segment counters instead of dividers.
module brick_grid_locator
  import brick_field_pkg::*;
#(
  parameter int H_TOT   = 800,
  parameter int ROWS    = 5,
  parameter int COLS    = 5,
  parameter int BRICK_W = 80,
  parameter int BRICK_H = 30,
  parameter int SPACE_X = 40,
  parameter int SPACE_Y = 20,
  parameter int FIRST_Y = 40,
  localparam int RW = $clog2(ROWS + 1),
  localparam int CW = $clog2(COLS + 1)
) (
  input  logic          CLK_25MH,
  input  logic          reset_n,
  input  logic [9:0]    hcount,
  input  logic [9:0]    vcount,
  output logic          in_brick,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col
);

  logic [10:0]   hoff_q, hoff, hoff_n;
  logic [10:0]   voff_q, voff, voff_n;
  logic          hon_q, hon, hon_n;
  logic          von_q, von, von_n;
  logic [CW-1:0] col_q, col_n;
  logic [RW-1:0] row_q, row_n;
  logic [10:0]   vgap;

  // State registers hold the segment for the current count;
  // a zero count forces the leading-gap state.
  always_comb begin
    hoff = hoff_q;
    hon  = hon_q;
    col  = col_q;
    if (hcount == '0) begin
      hoff = '0;
      hon  = 1'b0;
      col  = '0;
    end
    hoff_n = hoff + 11'd1;
    hon_n  = hon;
    col_n  = col;
    if (!hon && hoff == 11'(SPACE_X - 1)) begin
      hoff_n = '0;
      hon_n  = 1'b1;
    end else if (hon && hoff == 11'(BRICK_W - 1)) begin
      hoff_n = '0;
      hon_n  = 1'b0;
      if (col != CW'(COLS))
        col_n = col + CW'(1);
    end
  end

  always_comb begin
    voff = voff_q;
    von  = von_q;
    row  = row_q;
    if (vcount == '0) begin
      voff = '0;
      von  = 1'b0;
      row  = '0;
    end
    vgap   = (row == '0) ? 11'(FIRST_Y) : 11'(SPACE_Y);
    voff_n = voff + 11'd1;
    von_n  = von;
    row_n  = row;
    if (!von && voff == vgap - 11'd1) begin
      voff_n = '0;
      von_n  = 1'b1;
    end else if (von && voff == 11'(BRICK_H - 1)) begin
      voff_n = '0;
      von_n  = 1'b0;
      if (row != RW'(ROWS))
        row_n = row + RW'(1);
    end
  end

  assign in_brick = hon && von &&
                    col < CW'(COLS) &&
                    row < RW'(ROWS);

  always_ff @(posedge CLK_25MH or negedge reset_n) begin
    if (!reset_n) begin
      hoff_q <= '0;
      hon_q  <= 1'b0;
      col_q  <= '0;
      voff_q <= '0;
      von_q  <= 1'b0;
      row_q  <= '0;
    end else begin
      hoff_q <= hoff_n;
      hon_q  <= hon_n;
      col_q  <= col_n;
      if (hcount == 10'(H_TOT - 1)) begin
        voff_q <= voff_n;
        von_q  <= von_n;
        row_q  <= row_n;
      end
    end
  end

endmodule

// File: rtl/brick_field_vga.sv
// brick_field_vga: VGA timing plus brick field, ball and
// paddle renderer with a vblank-synchronised brick mask.
module brick_field_vga
  import brick_field_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int BRICK_W   = 80,
  parameter int BRICK_H   = 30,
  parameter int SPACE_X   = 40,
  parameter int SPACE_Y   = 20,
  parameter int FIRST_Y   = 40,
  parameter logic [3*ROWS-1:0] ROW_COLORS = DEF_ROW_COLORS,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_Y  = 440,
  parameter int PADDLE_H  = 10,
  parameter int PADDLE_W  = 100,
  parameter rgb3_t PADDLE_RGB = 3'b001,
  parameter rgb3_t BALL_RGB   = 3'b101,
  localparam int NB   = ROWS * COLS,
  localparam int IDXW = $clog2(NB)
) (
  input  logic            CLK_25MH,
  input  logic            reset_n,
  input  logic            restart,
  input  logic [9:0]      ball_x,
  input  logic [9:0]      ball_y,
  input  logic [9:0]      paddle_pos,
  brick_field_vga_if.slave ers,
  output logic [9:0]      hor_count,
  output logic [9:0]      ver_count,
  output logic            frame_start,
  output logic [IDXW:0]   bricks_left,
  output logic            all_clear,
  output rgb3_t           RGB,
  output logic            hsync,
  output logic            vsync
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS + 1);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [IDXW:0] NB_CNT = (IDXW + 1)'(NB);

  if (COLS * (BRICK_W + SPACE_X) + SPACE_X > H_ACTIVE) begin : g_bad
    $error("brick field wider than active area");
  end

  logic h_end, v_end, vblank_in;
  assign h_end     = hor_count == 10'(H_TOT - 1);
  assign v_end     = ver_count == 10'(V_TOT - 1);
  assign vblank_in = h_end && ver_count == 10'(V_ACTIVE - 1);

  always_ff @(posedge CLK_25MH or negedge reset_n) begin
    if (!reset_n) begin
      hor_count   <= '0;
      ver_count   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= h_end && v_end;
      if (h_end) begin
        hor_count <= '0;
        ver_count <= v_end ? '0 : ver_count + 10'd1;
      end else begin
        hor_count <= hor_count + 10'd1;
      end
    end
  end

  logic          in_brick;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  brick_grid_locator #(
    .H_TOT  (H_TOT),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .BRICK_W(BRICK_W),
    .BRICK_H(BRICK_H),
    .SPACE_X(SPACE_X),
    .SPACE_Y(SPACE_Y),
    .FIRST_Y(FIRST_Y)
  ) u_loc (
    .CLK_25MH(CLK_25MH),
    .reset_n (reset_n),
    .hcount  (hor_count),
    .vcount  (ver_count),
    .in_brick(in_brick),
    .row     (row),
    .col     (col)
  );

  logic [NB-1:0]   live_mask, disp_mask;
  logic [IDXW-1:0] idx;
  logic            pos_ok, live_hit;

  assign idx = IDXW'(brick_idx(int'(row), int'(col), COLS));
  assign pos_ok = {1'b0, ers.erase_pos} < NB_CNT;
  assign live_hit = pos_ok && live_mask[ers.erase_pos];

  // restart overrides both masks, so it also wins over erase
  always_ff @(posedge CLK_25MH or negedge reset_n) begin
    if (!reset_n) begin
      live_mask     <= '1;
      disp_mask     <= '1;
      bricks_left   <= NB_CNT;
      ers.erase_ack <= 1'b0;
      ers.erase_hit <= 1'b0;
    end else begin
      ers.erase_ack <= ers.erase_valid;
      ers.erase_hit <= 1'b0;
      if (vblank_in)
        disp_mask <= live_mask;
      if (restart) begin
        live_mask   <= '1;
        disp_mask   <= '1;
        bricks_left <= NB_CNT;
      end else if (ers.erase_valid && live_hit) begin
        ers.erase_hit           <= 1'b1;
        live_mask[ers.erase_pos] <= 1'b0;
        bricks_left             <= bricks_left - 1'b1;
      end
    end
  end

  assign all_clear = bricks_left == '0;

  logic [10:0] hx, vy, bx, by, px;
  logic        active, on_pad, on_ball, on_brick;
  rgb3_t       brick_rgb, pix;

  assign hx = {1'b0, hor_count};
  assign vy = {1'b0, ver_count};
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign px = {1'b0, paddle_pos};

  assign active = hx < 11'(H_ACTIVE) && vy < 11'(V_ACTIVE);
  assign on_pad = vy > 11'(PADDLE_Y) &&
                  vy < 11'(PADDLE_Y + PADDLE_H) &&
                  hx > px && hx < px + 11'(PADDLE_W);
  assign on_ball = hx >= bx && hx < bx + 11'(BALL_SIZE) &&
                   vy >= by && vy < by + 11'(BALL_SIZE);
  assign on_brick = in_brick && disp_mask[idx];
  assign brick_rgb = ROW_COLORS[3*int'(row) +: 3];

  always_comb begin
    pix = '0;
    if (active) begin
      if (on_pad)
        pix = PADDLE_RGB;
      else if (on_ball)
        pix = BALL_RGB;
      else if (on_brick)
        pix = brick_rgb;
    end
  end

  always_ff @(posedge CLK_25MH or negedge reset_n) begin
    if (!reset_n) begin
      RGB   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      RGB   <= pix;
      hsync <= !(hx >= HS_ON && hx < HS_OFF);
      vsync <= !(vy >= VS_ON && vy < VS_OFF);
    end
  end

endmodule

// File: tb/tb_brick_field_vga.sv
// tb_brick_field_vga: directed checks on a scaled-down
// screen (80x55 total, 12-pixel brick pitch).
module tb_brick_field_vga;

  localparam int LIM = 9000;

  logic       clk, rst_n, restart;
  logic [9:0] ball_x, ball_y, paddle_pos;
  logic [9:0] hor, ver;
  logic       fs, ac, hs, vs;
  logic [5:0] left;
  logic [2:0] rgb;

  brick_field_vga_if #(.IDXW(5)) ers ();

  brick_field_vga #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .BRICK_W(8), .BRICK_H(3), .SPACE_X(4),
    .SPACE_Y(2), .FIRST_Y(4), .BALL_SIZE(2),
    .PADDLE_Y(40), .PADDLE_H(4), .PADDLE_W(10)
  ) dut (
    .CLK_25MH   (clk),
    .reset_n    (rst_n),
    .restart    (restart),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle_pos (paddle_pos),
    .ers        (ers),
    .hor_count  (hor),
    .ver_count  (ver),
    .frame_start(fs),
    .bricks_left(left),
    .all_clear  (ac),
    .RGB        (rgb),
    .hsync      (hs),
    .vsync      (vs)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_acc = 0, vs_acc = 0, hs_last = 0, vs_last = 0;
  int fs_prev = 0, fs_period = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fs) begin
      hs_last   <= hs_acc;
      vs_last   <= vs_acc;
      fs_period <= cyc - fs_prev;
      fs_prev   <= cyc;
      hs_acc    <= int'(!hs);
      vs_acc    <= int'(!vs);
    end else begin
      hs_acc <= hs_acc + int'(!hs);
      vs_acc <= vs_acc + int'(!vs);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic wait_at(input int h, input int v);
    int n = 0;
    while (!(hor == 10'(h) && ver == 10'(v)) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pos", 32'(n < LIM), 1);
  endtask

  task automatic wait_fs();
    int n = 0;
    while (!fs && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("fs_seen", 32'(fs), 1);
    chk("fs_h0", 32'(hor), 0);
    chk("fs_v0", 32'(ver), 0);
  endtask

  task automatic px(input string tag, input int h,
                    input int v, input logic [2:0] want);
    wait_at(h, v);
    @(negedge clk);
    chk(tag, 32'(rgb), 32'(want));
  endtask

  int nack, nhit;

  initial begin
    rst_n = 1'b0;
    restart = 1'b0;
    ball_x = 10'd40;
    ball_y = 10'd19;
    paddle_pos = 10'd3;
    ers.erase_valid = 1'b0;
    ers.erase_pos = '0;
    repeat (3) @(negedge clk);
    chk("rst_h", 32'(hor), 0);
    chk("rst_v", 32'(ver), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_hs", 32'(hs), 1);
    chk("rst_vs", 32'(vs), 1);
    chk("rst_ack", 32'(ers.erase_ack), 0);
    chk("rst_hit", 32'(ers.erase_hit), 0);
    chk("rst_fs", 32'(fs), 0);
    chk("rst_left", 32'(left), 25);
    chk("rst_clr", 32'(ac), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_h", 32'(hor), 1);
    chk("first_v", 32'(ver), 0);

    wait_at(68, 0);
    chk("hs_pre", 32'(hs), 1);
    @(negedge clk);
    chk("hs_fall", 32'(hs), 0);
    wait_at(76, 0);
    chk("hs_end", 32'(hs), 0);
    @(negedge clk);
    chk("hs_rise", 32'(hs), 1);

    px("brk_r0c0", 4, 4, 3'b010);
    px("brk_xedge", 12, 4, 3'b000);
    px("brk_last", 11, 6, 3'b010);
    px("brk_yedge", 4, 7, 3'b000);
    px("brk7_pre", 28, 9, 3'b110);
    px("ball_over", 40, 19, 3'b101);
    px("ball_xedge", 42, 19, 3'b100);
    px("brk_r4c1", 16, 24, 3'b011);
    px("pad_edge", 3, 41, 3'b000);
    px("paddle", 5, 41, 3'b001);
    ball_x = 10'd6;
    ball_y = 10'd42;
    px("pad_ball", 6, 42, 3'b001);

    wait_at(0, 50);
    chk("vs_pre", 32'(vs), 1);
    @(negedge clk);
    chk("vs_low", 32'(vs), 0);
    wait_at(1, 52);
    chk("vs_rise", 32'(vs), 1);
    ball_x = 10'd1000;
    ball_y = 10'd1000;
    paddle_pos = 10'd1000;

    wait_fs();
    ers.erase_valid = 1'b1;
    ers.erase_pos = 5'd7;
    @(negedge clk);
    chk("er7_ack", 32'(ers.erase_ack), 1);
    chk("er7_hit", 32'(ers.erase_hit), 1);
    chk("er7_left", 32'(left), 24);
    @(negedge clk);
    chk("rep_ack", 32'(ers.erase_ack), 1);
    chk("rep_hit", 32'(ers.erase_hit), 0);
    chk("rep_left", 32'(left), 24);
    ers.erase_pos = 5'd30;
    @(negedge clk);
    chk("oor_ack", 32'(ers.erase_ack), 1);
    chk("oor_hit", 32'(ers.erase_hit), 0);
    chk("oor_left", 32'(left), 24);
    ers.erase_valid = 1'b0;
    @(negedge clk);
    chk("ack_pulse", 32'(ers.erase_ack), 0);
    px("erase_hold", 28, 9, 3'b110);

    wait_fs();
    @(negedge clk);
    chk("fs_pulse", 32'(fs), 0);
    chk("hs_count", 32'(hs_last), 440);
    chk("vs_count", 32'(vs_last), 160);
    chk("fs_period", 32'(fs_period), 4400);
    px("erase_shown", 28, 9, 3'b000);

    restart = 1'b1;
    ers.erase_valid = 1'b1;
    ers.erase_pos = 5'd3;
    @(negedge clk);
    restart = 1'b0;
    ers.erase_valid = 1'b0;
    chk("rs_ack", 32'(ers.erase_ack), 1);
    chk("rs_hit", 32'(ers.erase_hit), 0);
    chk("rs_left", 32'(left), 25);
    px("rs_draw", 28, 11, 3'b110);

    nack = 0;
    nhit = 0;
    ers.erase_valid = 1'b1;
    ers.erase_pos = 5'd0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      nack += int'(ers.erase_ack);
      nhit += int'(ers.erase_hit);
      if (i < 25)
        ers.erase_pos = 5'(i);
      else
        ers.erase_valid = 1'b0;
    end
    chk("b2b_acks", 32'(nack), 25);
    chk("b2b_hits", 32'(nhit), 25);
    chk("b2b_left", 32'(left), 0);
    chk("all_clear", 32'(ac), 1);
    px("no_tear", 40, 19, 3'b100);

    wait_fs();
    px("cleared", 4, 4, 3'b000);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs2_left", 32'(left), 25);
    chk("rs2_clr", 32'(ac), 0);
    wait_at(6, 9);
    chk("pre_reset", 32'(rgb), 32'(3'b110));

    #5 rst_n = 1'b0;
    #1;
    chk("arst_h", 32'(hor), 0);
    chk("arst_v", 32'(ver), 0);
    chk("arst_rgb", 32'(rgb), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_h", 32'(hor), 1);
    chk("post_rst_v", 32'(ver), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
